segment_step_scheduler: RTL and testbench

//   Decides when and in which direction the active segment of the 6-segment display advances.

---
 rtl/segment_step_scheduler.sv | 169 ++++++++++++++++
 tb/tb_segment_step_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/segment_step_scheduler.sv
// segment_step_scheduler
//   Chooses when the active segment of the segment display advances, and in which
//   direction. Manual step requests, direction toggles and an internal auto-step
//   timebase are merged into one registered step. The block drives a one-hot segment
//   vector and a single-cycle step strobe.
//
//   Optional feature: define SEG_SCHED_BLINK_EN to blank the segments on alternate
//   ticks while in HOLD. When the macro is undefined, HOLD shows a steady one-hot.
//
// Ports
//   clk                  in   1        system clock, rising edge
//   async_nreset         in   1        asynchronous active-low reset
//   btn_next_segment_re  in   1        one-cycle manual step request
//   btn_mode_re          in   1        one-cycle request to advance the mode
//   btn_dir_re           in   1        one-cycle request to toggle the direction
//   step_pulse           out  1        high in the cycle seg_index changes
//   seg_index            out  IDX_W    active segment index, 0..NUM_SEG-1
//   segments             out  NUM_SEG  1 << seg_index (zero while blanked)
//   current_mode         out  2        00 MANUAL, 01 AUTO_FWD, 10 AUTO_PINGPONG, 11 HOLD
//   dir                  out  1        0 = index increments, 1 = index decrements
module segment_step_scheduler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned NUM_SEG  = 6,
    parameter int unsigned IDX_W    = 3
) (
    input  logic               clk,
    input  logic               async_nreset,
    input  logic               btn_next_segment_re,
    input  logic               btn_mode_re,
    input  logic               btn_dir_re,
    output logic               step_pulse,
    output logic [IDX_W-1:0]   seg_index,
    output logic [NUM_SEG-1:0] segments,
    output logic [1:0]         current_mode,
    output logic               dir
);

    localparam int unsigned          CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_AUTO_FWD = 2'b01,
        MODE_AUTO_PP  = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic [NUM_SEG-1:0] seg_q, seg_d;
    logic               step_q, step_d;
    logic               blank_d;

    logic tick;
    logic is_auto;
    logic step_req;
    logic dir_eff;

`ifdef SEG_SCHED_BLINK_EN
    logic blink_q, blink_d;
`endif

    always_comb begin
        is_auto  = (mode_q == MODE_AUTO_FWD) || (mode_q == MODE_AUTO_PP);
        tick     = (mode_q != MODE_MANUAL) && (cnt_q == CNT_MAX);
        // A mode change drops any step requested in the same cycle.
        step_req = !btn_mode_re &&
                   (((mode_q == MODE_MANUAL) && btn_next_segment_re) ||
                    (is_auto && (btn_next_segment_re || tick)));
        // A direction toggle is applied before the step in the same cycle.
        dir_eff  = dir_q ^ (btn_dir_re &&
                            ((mode_q == MODE_MANUAL) || (mode_q == MODE_AUTO_FWD)));

        mode_d = mode_q;
        if (btn_mode_re) begin
            case (mode_q)
                MODE_MANUAL:   mode_d = MODE_AUTO_FWD;
                MODE_AUTO_FWD: mode_d = MODE_AUTO_PP;
                MODE_AUTO_PP:  mode_d = MODE_HOLD;
                default:       mode_d = MODE_MANUAL;
            endcase
        end

        if (btn_mode_re || (mode_q == MODE_MANUAL) || tick ||
            (is_auto && btn_next_segment_re)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        idx_d  = idx_q;
        dir_d  = dir_eff;
        step_d = step_req;
        if (step_req) begin
            if (mode_q == MODE_AUTO_PP) begin
                // Bounce at the ends: the direction flips together with the step.
                if (!dir_eff) begin
                    if (idx_q == IDX_MAX) begin
                        idx_d = idx_q - IDX_W'(1);
                        dir_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    if (idx_q == '0) begin
                        idx_d = IDX_W'(1);
                        dir_d = 1'b0;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end else begin
                if (!dir_eff) begin
                    idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    idx_d = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
                end
            end
        end

`ifdef SEG_SCHED_BLINK_EN
        blink_d = blink_q;
        if ((mode_q != MODE_HOLD) || btn_mode_re) begin
            blink_d = 1'b0;
        end else if (tick) begin
            blink_d = ~blink_q;
        end
        blank_d = blink_d;
`else
        blank_d = 1'b0;
`endif

        seg_d = blank_d ? '0 : (NUM_SEG'(1) << idx_d);
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mode_q  <= MODE_MANUAL;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            seg_q   <= NUM_SEG'(1);
            step_q  <= 1'b0;
`ifdef SEG_SCHED_BLINK_EN
            blink_q <= 1'b0;
`endif
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            seg_q   <= seg_d;
            step_q  <= step_d;
`ifdef SEG_SCHED_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign step_pulse   = step_q;
    assign seg_index    = idx_q;
    assign segments     = seg_q;
    assign current_mode = mode_q;
    assign dir          = dir_q;

endmodule

// File: tb/tb_segment_step_scheduler.sv
// tb_segment_step_scheduler
//   Directed bench for segment_step_scheduler with TICK_DIV=4, NUM_SEG=6, IDX_W=3.
//   Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_segment_step_scheduler;

    logic       clk = 1'b0;
    logic       async_nreset = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_dir = 1'b0;
    logic       step_pulse;
    logic [2:0] seg_index;
    logic [5:0] segments;
    logic [1:0] current_mode;
    logic       dir;

    int checks = 0;
    int errors = 0;

    segment_step_scheduler #(
        .TICK_DIV(4),
        .NUM_SEG (6),
        .IDX_W   (3)
    ) dut (
        .clk                (clk),
        .async_nreset       (async_nreset),
        .btn_next_segment_re(btn_next),
        .btn_mode_re        (btn_mode),
        .btn_dir_re         (btn_dir),
        .step_pulse         (step_pulse),
        .seg_index          (seg_index),
        .segments           (segments),
        .current_mode       (current_mode),
        .dir                (dir)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idx(input string tag, input int unsigned idx);
        logic [5:0] oh;
        oh = 6'd1 << idx;
        check({tag, "_idx"}, 32'(seg_index), 32'(idx));
        check({tag, "_seg"}, 32'(segments), 32'(oh));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_idx"},   32'(seg_index),    0);
        check({tag, "_seg"},   32'(segments),     1);
        check({tag, "_mode"},  32'(current_mode), 0);
        check({tag, "_dir"},   32'(dir),          0);
        check({tag, "_pulse"}, 32'(step_pulse),   0);
    endtask

    // Cycles until the next step_pulse, bounded; a timeout returns 20.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < 20);
    endtask

    task automatic pulse_mode;
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_next;
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
    endtask

    initial begin
        int n;
        int unsigned wrap_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
        int unsigned pp_idx[10]  = '{5, 4, 3, 2, 1, 0, 1, 2, 3, 4};
        int unsigned pp_dir[10]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [5:0]  exp_seg;

        // Reset
        repeat (3) @(negedge clk);
        check_reset_state("in_reset");
        async_nreset = 1'b1;
        @(negedge clk);
        check_reset_state("post_reset");

        // Manual wrap
        foreach (wrap_seq[i]) begin
            pulse_next();
            check("man_pulse", 32'(step_pulse), 1);
            check_idx("man", wrap_seq[i]);
            @(negedge clk);
            check("man_pulse_end", 32'(step_pulse), 0);
        end
        btn_dir = 1'b1;
        @(negedge clk);
        btn_dir = 1'b0;
        check("dir_toggle", 32'(dir), 1);
        check("dir_no_pulse", 32'(step_pulse), 0);
        pulse_next();
        check_idx("down1", 0);
        pulse_next();
        check_idx("down_wrap", 5);

        // Direction toggle and step together: the step goes up
        btn_dir  = 1'b1;
        btn_next = 1'b1;
        @(negedge clk);
        btn_dir  = 1'b0;
        btn_next = 1'b0;
        check("dirstep_dir", 32'(dir), 0);
        check_idx("dirstep", 0);

        // Mode and next together in MANUAL: mode advances, no step
        btn_mode = 1'b1;
        btn_next = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        check("coll_mode", 32'(current_mode), 1);
        check("coll_pulse", 32'(step_pulse), 0);
        check_idx("coll", 0);

        // Auto timing
        wait_step(n);
        check("auto_gap1", 32'(n), 4);
        check_idx("auto1", 1);
        wait_step(n);
        check("auto_gap2", 32'(n), 4);
        check_idx("auto2", 2);
        repeat (2) @(negedge clk);
        pulse_next();
        check("auto_btn_pulse", 32'(step_pulse), 1);
        check_idx("auto_btn", 3);
        wait_step(n);
        check("auto_after_btn", 32'(n), 4);
        check_idx("auto3", 4);

        // Tick and button in the same cycle: one step only
        repeat (3) @(negedge clk);
        pulse_next();
        check("tickbtn_pulse", 32'(step_pulse), 1);
        check_idx("tickbtn", 5);
        @(negedge clk);
        check("tickbtn_single", 32'(step_pulse), 0);
        check_idx("tickbtn_hold", 5);
        wait_step(n);
        check("tickbtn_next", 32'(n), 3);
        check_idx("auto_wrap", 0);

        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            check("auto_run_gap", 32'(n), 4);
        end
        check_idx("auto_run", 4);

        // Ping-pong from index 4 with dir=0
        pulse_mode();
        check("pp_mode", 32'(current_mode), 2);
        check("pp_dir_kept", 32'(dir), 0);
        check_idx("pp_entry", 4);
        for (int i = 0; i < 10; i++) begin
            wait_step(n);
            check("pp_gap", 32'(n), 4);
            check_idx("pp", pp_idx[i]);
            check("pp_dir", 32'(dir), 32'(pp_dir[i]));
        end
        for (int i = 0; i < 3; i++) wait_step(n);
        check_idx("pp_pre_rst", 3);
        check("pp_pre_rst_dir", 32'(dir), 1);

        // Reset mid-run, with a partial tick count pending
        repeat (2) @(negedge clk);
        #3 async_nreset = 1'b0;
        #1 check_reset_state("midrun_rst");
        @(negedge clk);
        @(negedge clk);
        async_nreset = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (step_pulse) n++;
        end
        check("manual_no_tick", 32'(n), 0);
        pulse_mode();
        check("rst_auto_mode", 32'(current_mode), 1);
        wait_step(n);
        check("rst_first_tick", 32'(n), 4);
        check_idx("rst_auto", 1);

        // HOLD: index frozen, button ignored
        pulse_mode();
        check("to_pp_mode", 32'(current_mode), 2);
        pulse_mode();
        check("hold_mode", 32'(current_mode), 3);
        for (int k = 1; k <= 16; k++) begin
`ifdef SEG_SCHED_BLINK_EN
            exp_seg = ((((k - 1) / 4) % 2) != 0) ? 6'd0 : 6'd2;
`else
            exp_seg = 6'd2;
`endif
            check("hold_pulse", 32'(step_pulse), 0);
            check("hold_idx", 32'(seg_index), 1);
            check("hold_seg", 32'(segments), 32'(exp_seg));
            btn_next = (k == 6);
            btn_mode = (k == 16);
            @(negedge clk);
        end
        btn_next = 1'b0;
        btn_mode = 1'b0;
        check("exit_hold_mode", 32'(current_mode), 0);
        check_idx("exit_hold", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
